// File: rtl/ram_arbiter.sv
// Two-port (CPU "C" / DMA "D") arbiter in front of a single-port synchronous RAM.
// Round-robin on ties by default; define ARB_CPU_PRIORITY_EN for C priority with a starvation guard.
module ram_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata,
  output logic [1:0]    owner
);

  typedef enum logic [2:0] {IDLE, C_ACC, C_ACK, D_ACC, D_ACK} state_t;

  state_t state, next;
  logic   tie_c;   // C wins when both request in IDLE
  logic   d_cont;  // C_ACK may hand straight over to a waiting D

`ifdef ARB_CPU_PRIORITY_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [SW-1:0] starve;

  assign tie_c  = (starve != SMAX);
  assign d_cont = (starve == SMAX);

  always_ff @(posedge clk) begin
    if (rst)                          starve <= '0;
    else if (!d_req || next == D_ACC) starve <= '0;
    else if (next == C_ACC && starve != SMAX) starve <= starve + 1'b1;
  end
`else
  logic last_d;  // 1: D was served last

  assign tie_c  = last_d;
  assign d_cont = 1'b1;

  always_ff @(posedge clk) begin
    if (rst)                 last_d <= 1'b1;
    else if (state == C_ACK) last_d <= 1'b0;
    else if (state == D_ACK) last_d <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: begin
        if (c_req && (!d_req || tie_c)) next = C_ACC;
        else if (d_req)                 next = D_ACC;
      end
      C_ACC:   next = C_ACK;
      D_ACC:   next = D_ACK;
      // the acked port's own req is not looked at here
      C_ACK:   next = (d_req && d_cont) ? D_ACC : IDLE;
      D_ACK:   next = c_req ? C_ACC : IDLE;
      default: next = IDLE;
    endcase
  end

  // address/data are latched on grant so they hold after the access
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else if (next == C_ACC) begin
      ram_addr  <= c_addr;
      ram_wdata <= c_wdata;
    end else if (next == D_ACC) begin
      ram_addr  <= d_addr;
      ram_wdata <= d_wdata;
    end
  end

  assign ram_we  = (state == C_ACC && c_we) || (state == D_ACC && d_we);
  assign c_ack   = (state == C_ACK);
  assign d_ack   = (state == D_ACK);
  assign c_rdata = c_ack ? ram_rdata : '0;
  assign d_rdata = d_ack ? ram_rdata : '0;

  always_comb begin
    owner = 2'b00;
    if (state == C_ACC || state == C_ACK) owner = 2'b01;
    if (state == D_ACC || state == D_ACK) owner = 2'b10;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural sync-read RAM.
// Build with ARB_CPU_PRIORITY_EN to exercise the C-priority sequence instead of round-robin.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [AW-1:0] c_addr, d_addr, ram_addr;
  logic [DW-1:0] c_wdata, d_wdata, c_rdata, d_rdata, ram_wdata, ram_rdata;
  logic          c_ack, d_ack, ram_we;
  logic [1:0]    owner;
  logic [DW-1:0] mem [256];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ack(c_ack), .c_rdata(c_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    do_reset();

    // reset state
    chk("rst_c_ack", c_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_owner", owner, 0);

    // single C write
    c_req = 1; c_we = 1; c_addr = 8'h12; c_wdata = 16'hBEEF;
    chk("t1_we_idle", ram_we, 0);
    step();
    chk("t1_we_acc", ram_we, 1);
    chk("t1_addr", ram_addr, 8'h12);
    chk("t1_wdata", ram_wdata, 16'hBEEF);
    chk("t1_owner_acc", owner, 2'b01);
    chk("t1_noack_acc", c_ack, 0);
    step();
    chk("t1_ack", c_ack, 1);
    chk("t1_we_ack", ram_we, 0);
    c_req = 0;
    step();
    chk("t1_ack_drop", c_ack, 0);
    chk("t1_owner_idle", owner, 2'b00);
    chk("t1_addr_hold", ram_addr, 8'h12);

    // C read back
    c_req = 1; c_we = 0;
    step();
    chk("t2_we_acc", ram_we, 0);
    chk("t2_owner", owner, 2'b01);
    chk("t2_rdata_acc", c_rdata, 0);
    step();
    chk("t2_ack", c_ack, 1);
    chk("t2_rdata", c_rdata, 16'hBEEF);
    chk("t2_we_ack", ram_we, 0);
    c_req = 0;
    step();
    chk("t2_ack_drop", c_ack, 0);
    chk("t2_rdata_idle", c_rdata, 0);

    // reset in the middle of a C write
    c_req = 1; c_we = 1; c_addr = 8'h40; c_wdata = 16'h1234;
    step();
    chk("t5_we_acc", ram_we, 1);
    rst = 1;
    step();
    rst = 0;
    chk("t5_no_ack", c_ack, 0);
    chk("t5_we", ram_we, 0);
    chk("t5_addr", ram_addr, 0);
    chk("t5_wdata", ram_wdata, 0);
    chk("t5_owner", owner, 0);
    step();
    chk("t5_owner_again", owner, 2'b01);
    chk("t5_addr_again", ram_addr, 8'h40);
    step();
    chk("t5_ack_again", c_ack, 1);
    c_req = 0;
    step();

    // D write with C read of the same address queued behind it
    d_req = 1; d_we = 1; d_addr = 8'h03; d_wdata = 16'h55AA;
    step();
    chk("t6_d_owner", owner, 2'b10);
    chk("t6_d_we", ram_we, 1);
    c_req = 1; c_we = 0; c_addr = 8'h03;
    step();
    chk("t6_d_ack", d_ack, 1);
    chk("t6_c_noack", c_ack, 0);
    d_req = 0;
    step();
    chk("t6_c_owner", owner, 2'b01);
    chk("t6_c_addr", ram_addr, 8'h03);
    step();
    chk("t6_c_ack", c_ack, 1);
    chk("t6_c_rdata", c_rdata, 16'h55AA);
    c_req = 0;
    step();

`ifndef ARB_CPU_PRIORITY_EN
    // simultaneous requests: strict alternation, C first after reset
    do_reset();
    begin
      int nc = 0, nd = 0;
      c_req = 1; c_we = 0; c_addr = 8'h12;
      d_req = 1; d_we = 0; d_addr = 8'h03;
      for (int k = 1; k <= 16; k++) begin
        step();
        chk("t3_both_ack", c_ack & d_ack, 0);
        chk("t3_c_ack", c_ack, (k % 4 == 2));
        chk("t3_d_ack", d_ack, (k % 4 == 0));
        if (c_ack) begin
          chk("t3_c_rdata", c_rdata, 16'hBEEF);
          nc++;
          if (nc == 4) c_req = 0;
        end
        if (d_ack) begin
          chk("t3_d_rdata", d_rdata, 16'h55AA);
          nd++;
          if (nd == 4) d_req = 0;
        end
      end
      chk("t3_c_count", nc, 4);
      chk("t3_d_count", nd, 4);
      step();
      chk("t3_idle_owner", owner, 0);
    end
`else
    // C priority with starvation guard: C,C,C,C,D repeating
    do_reset();
    begin
      int n = 0;
      c_req = 1; c_we = 0; c_addr = 8'h12;
      d_req = 1; d_we = 0; d_addr = 8'h03;
      for (int k = 0; k < 80 && n < 15; k++) begin
        step();
        chk("t4_both_ack", c_ack & d_ack, 0);
        if (c_ack || d_ack) begin
          chk("t4_grant_is_d", d_ack, (n % 5 == 4));
          n++;
        end
      end
      chk("t4_ack_count", n, 15);
      c_req = 0; d_req = 0;
      step();
      step();
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
